// File: rtl/preset_flash_writer.sv
// Preset write path: keeps a shadow copy of every preset word, coalesces saves, then erases and reprograms the flash sector.
// Optional macro PRESET_VERIFY_EN adds a read-back check after each programmed word.
module preset_flash_writer #(
  parameter int          BUTTONS_CNT = 4,
  parameter logic [23:0] MEMADDR     = 24'h1ffd80,
  parameter int          QUIET_CNT   = 1000000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_stb,
  input  logic [2:0]  load_idx,
  input  logic [31:0] load_word,
  input  logic        save_stb,
  input  logic [2:0]  save_idx,
  input  logic [31:0] save_word,
  output logic [23:0] spi_adr_o,
  output logic [31:0] spi_dat_o,
  output logic        spi_we_o,
  output logic        spi_erase_o,
  output logic        spi_stb_o,
  input  logic [31:0] spi_dat_i,
  input  logic        spi_ack_i,
  input  logic        spi_rty_i,
  output logic        busy,
  output logic        err
);
  localparam int         CNT_W = $clog2(QUIET_CNT + 1);
  localparam int         RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [2:0] LAST  = 3'(BUTTONS_CNT);

`ifdef PRESET_VERIFY_EN
  typedef enum logic [2:0] {IDLE, QUIET, ERASE, PROG, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, QUIET, ERASE, PROG, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [31:0]       shadow [0:7];
  logic [CNT_W-1:0]  quiet_cnt;
  logic [RTY_W-1:0]  retry;
  logic [2:0]        k;
  logic              stb_q, dirty, pending;
  logic [23:0]       adr_q;
  logic [31:0]       dat_q;

  logic save_ok, load_ok, in_flush, pend_now, ack_ev, rty_ev, last_word;
  logic quiet_done, vbad, retry_out, op_state, issue, advance, ack_clear;

  assign save_ok    = save_stb && (save_idx != 3'd0) && (save_idx <= LAST);
  assign load_ok    = load_stb && (load_idx != 3'd0) && (load_idx <= LAST);
  assign in_flush   = (state != IDLE) && (state != QUIET);
  assign pend_now   = pending || (save_ok && in_flush);
  assign ack_ev     = stb_q && spi_ack_i;
  assign rty_ev     = stb_q && spi_rty_i && !spi_ack_i;
  assign last_word  = (k == LAST);
  assign quiet_done = (state == QUIET) && !save_ok && (quiet_cnt == CNT_W'(QUIET_CNT - 1));
  assign retry_out  = (rty_ev || vbad) && (retry == RTY_W'(MAX_RETRY));
  assign issue      = op_state && !stb_q && !spi_ack_i && !spi_rty_i;

`ifdef PRESET_VERIFY_EN
  // A read-back mismatch is treated like a refused operation and re-programs the same slot.
  assign vbad      = ack_ev && (state == VERIFY) && (spi_dat_i != shadow[k]);
  assign op_state  = (state == ERASE) || (state == PROG) || (state == VERIFY);
  assign advance   = ack_ev && (state == VERIFY) && !vbad && !last_word;
  assign ack_clear = ack_ev && (state != PROG) && !vbad;
`else
  logic unused_dat;
  assign unused_dat = ^spi_dat_i;
  assign vbad       = 1'b0;
  assign op_state   = (state == ERASE) || (state == PROG);
  assign advance    = ack_ev && (state == PROG) && !last_word;
  assign ack_clear  = ack_ev;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (dirty) state_nxt = QUIET;
      QUIET:  if (quiet_done) state_nxt = ERASE;
      ERASE:  if (ack_ev) state_nxt = PROG;
              else if (retry_out) state_nxt = IDLE;
`ifdef PRESET_VERIFY_EN
      PROG:   if (ack_ev) state_nxt = VERIFY;
              else if (retry_out) state_nxt = IDLE;
      VERIFY: if (retry_out) state_nxt = IDLE;
              else if (ack_ev) state_nxt = (vbad || !last_word) ? PROG : DONE;
`else
      PROG:   if (ack_ev) state_nxt = last_word ? DONE : PROG;
              else if (retry_out) state_nxt = IDLE;
`endif
      DONE:   state_nxt = pend_now ? QUIET : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_stb_o   = stb_q;
    spi_adr_o   = adr_q;
    spi_dat_o   = dat_q;
    spi_we_o    = (state == PROG);
    spi_erase_o = (state == ERASE);
    busy        = (state != IDLE);
  end

  // Shadow is deliberately outside reset; a save to the same slot overrides a simultaneous load.
  always_ff @(posedge clk) begin
    if (load_ok) shadow[load_idx] <= load_word;
    if (save_ok) shadow[save_idx] <= save_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stb_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      k         <= 3'd1;
      retry     <= '0;
      quiet_cnt <= '0;
      dirty     <= 1'b0;
      pending   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state != QUIET || save_ok) quiet_cnt <= '0;
      else                           quiet_cnt <= quiet_cnt + CNT_W'(1);

      if (quiet_done)                   dirty <= 1'b0;
      else if (retry_out)               dirty <= pend_now;
      else if (state == DONE && pend_now) dirty <= 1'b1;
      else if (save_ok && !in_flush)    dirty <= 1'b1;

      if (retry_out || state == DONE) pending <= 1'b0;
      else if (save_ok && in_flush)   pending <= 1'b1;

      if (retry_out)          err <= 1'b1;
      else if (state == DONE) err <= 1'b0;

      if (state == IDLE || state == QUIET || state == DONE) retry <= '0;
      else if (rty_ev || vbad)                              retry <= retry + RTY_W'(1);
      else if (ack_clear)                                   retry <= '0;

      if (state == ERASE) k <= 3'd1;
      else if (advance)   k <= k + 3'd1;

      // Address and data are captured once per strobe so they stay stable until ack or rty.
      if (stb_q) begin
        if (ack_ev || rty_ev) stb_q <= 1'b0;
      end else if (issue) begin
        stb_q <= 1'b1;
        adr_q <= (state == ERASE) ? MEMADDR : MEMADDR + ((24'(k) - 24'd1) << 2);
        if (state == PROG) dat_q <= shadow[k];
      end
    end
  end
endmodule

// File: tb/tb_preset_flash_writer.sv
// Self-checking bench for preset_flash_writer: flash/bus responder model, vector table, corner sequences and random saves.
// Exercises the read-back path as well when PRESET_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_preset_flash_writer;
  localparam int          BUTTONS_CNT = 4;
  localparam logic [23:0] MEMADDR     = 24'h1ffd80;
  localparam int          QUIET_CNT   = 16;
  localparam int          MAX_RETRY   = 3;
`ifdef PRESET_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk, rst;
  logic        load_stb, save_stb;
  logic [2:0]  load_idx, save_idx;
  logic [31:0] load_word, save_word;
  logic [23:0] spi_adr_o;
  logic [31:0] spi_dat_o, spi_dat_i;
  logic        spi_we_o, spi_erase_o, spi_stb_o, spi_ack_i, spi_rty_i, busy, err;

  preset_flash_writer #(
    .BUTTONS_CNT(BUTTONS_CNT), .MEMADDR(MEMADDR), .QUIET_CNT(QUIET_CNT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst),
    .load_stb(load_stb), .load_idx(load_idx), .load_word(load_word),
    .save_stb(save_stb), .save_idx(save_idx), .save_word(save_word),
    .spi_adr_o(spi_adr_o), .spi_dat_o(spi_dat_o), .spi_we_o(spi_we_o),
    .spi_erase_o(spi_erase_o), .spi_stb_o(spi_stb_o), .spi_dat_i(spi_dat_i),
    .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit erase; bit we; logic [23:0] adr; logic [31:0] dat; int cyc; } op_t;
  typedef struct { logic [2:0] idx; logic [31:0] word; int exp_erases; logic [23:0] exp_adr; } vec_t;

  op_t         ops[$];
  op_t         cur;
  logic [31:0] flash [1:BUTTONS_CNT];
  logic [31:0] model [1:BUTTONS_CNT];
  int  vec_cnt = 0, mis_cnt = 0;
  int  ack_delay = 1, corrupt_slot = 0, save_cyc = 0;
  bit  rand_delay = 0, rty_erase = 0;
  int  stable_err = 0, gap_err = 0, adr_err = 0;
  bit  op_active = 0;
  int  wait_cnt = 0, cur_delay = 1;

  // Behavioural flash plus bus slave: logs each operation and answers after a programmable delay.
  initial begin
    int slot;
    spi_ack_i = 1'b0; spi_rty_i = 1'b0; spi_dat_i = '0;
    forever begin
      @(negedge clk);
      if (spi_ack_i || spi_rty_i) begin
        spi_ack_i = 1'b0; spi_rty_i = 1'b0;
        if (spi_stb_o) gap_err++;
      end else if (spi_stb_o) begin
        if (!op_active) begin
          cur.erase = spi_erase_o; cur.we = spi_we_o; cur.adr = spi_adr_o;
          cur.dat = spi_dat_o; cur.cyc = cyc;
          ops.push_back(cur);
          op_active = 1; wait_cnt = 0;
          cur_delay = rand_delay ? int'($urandom_range(1, 4)) : ack_delay;
        end else if (spi_adr_o !== cur.adr || spi_dat_o !== cur.dat ||
                     spi_we_o !== cur.we || spi_erase_o !== cur.erase) begin
          stable_err++;
        end
        wait_cnt++;
        if (wait_cnt >= cur_delay) begin
          op_active = 0;
          if (cur.erase && rty_erase) spi_rty_i = 1'b1;
          else begin
            slot = int'(cur.adr - MEMADDR) / 4 + 1;
            if (cur.erase) begin
              if (cur.adr != MEMADDR) adr_err++;
              for (int s = 1; s <= BUTTONS_CNT; s++) flash[s] = 32'hFFFF_FFFF;
            end else if (cur.adr < MEMADDR || cur.adr[1:0] != 2'b00 || slot > BUTTONS_CNT) begin
              adr_err++;
            end else if (cur.we) begin
              flash[slot] = cur.dat;
            end else if (corrupt_slot == slot) begin
              spi_dat_i = 32'hFFFF_FFFF; corrupt_slot = 0;
            end else begin
              spi_dat_i = flash[slot];
            end
            spi_ack_i = 1'b1;
          end
        end
      end else begin
        op_active = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [2:0] lidx, input logic [31:0] lword,
                               input logic sv, input logic [2:0] sidx, input logic [31:0] sword);
    @(posedge clk); #1;
    load_stb = ld; load_idx = lidx; load_word = lword;
    save_stb = sv; save_idx = sidx; save_word = sword;
    @(posedge clk); #1;
    save_cyc = cyc;
    load_stb = 1'b0; save_stb = 1'b0;
    if (ld && lidx >= 3'd1 && lidx <= 3'(BUTTONS_CNT)) model[lidx] = lword;
    if (sv && sidx >= 3'd1 && sidx <= 3'(BUTTONS_CNT)) model[sidx] = sword;
  endtask

  task automatic waitIdle(input string name);
    int quiet = 0, n = 0;
    while (quiet < 30 && n < 3000) begin
      @(negedge clk); n++;
      if (busy) quiet = 0; else quiet++;
    end
    checkOutput({name, " settles idle"}, quiet >= 30, 1);
  endtask

  task automatic waitOps(input int n, input string name);
    int t = 0;
    while (ops.size() < n && t < 500) begin @(negedge clk); t++; end
    checkOutput({name, " op reached"}, ops.size() >= n, 1);
  endtask

  function automatic int countKind(input bit e, input bit w);
    int c = 0;
    foreach (ops[i]) if (ops[i].erase == e && ops[i].we == w) c++;
    return c;
  endfunction

  function automatic int progIdx(input int k);
    return VERIFY ? 2 * k - 1 : k;
  endfunction

  // Reference flush: one erase, then every slot programmed in order (each followed by a read-back when verifying).
  task automatic checkFlush(input int start, input string name, input int bad_slot);
    op_t exp_q[$];
    op_t e;
    int  reps;
    e.cyc = 0; e.dat = '0;
    e.erase = 1; e.we = 0; e.adr = MEMADDR;
    exp_q.push_back(e);
    for (int s = 1; s <= BUTTONS_CNT; s++) begin
      reps = (VERIFY && s == bad_slot) ? 2 : 1;
      for (int r = 0; r < reps; r++) begin
        e.erase = 0; e.we = 1; e.adr = MEMADDR + 24'(4 * (s - 1)); e.dat = model[s];
        exp_q.push_back(e);
        if (VERIFY) begin e.we = 0; exp_q.push_back(e); end
      end
    end
    checkOutput($sformatf("%s op count", name), ops.size() - start, exp_q.size());
    for (int i = 0; i < exp_q.size() && start + i < ops.size(); i++) begin
      checkOutput($sformatf("%s op%0d kind", name, i),
                  {ops[start+i].erase, ops[start+i].we}, {exp_q[i].erase, exp_q[i].we});
      checkOutput($sformatf("%s op%0d adr", name, i), ops[start+i].adr, exp_q[i].adr);
      if (exp_q[i].we) checkOutput($sformatf("%s op%0d dat", name, i), ops[start+i].dat, exp_q[i].dat);
    end
  endtask

  task automatic checkFlash(input string name);
    for (int s = 1; s <= BUTTONS_CNT; s++)
      checkOutput($sformatf("%s flash slot%0d", name, s), flash[s], model[s]);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   flen, d, n, found;
    logic [31:0] got;
    logic [2:0]  idx;
    int   nsv;

    vecs[0] = '{3'd1, 32'h1111_1111, 1, 24'h1ffd80};
    vecs[1] = '{3'd4, 32'hCAFE_F00D, 1, 24'h1ffd8c};
    vecs[2] = '{3'd0, 32'hDEAD_BEEF, 0, 24'h000000};
    vecs[3] = '{3'd5, 32'h1234_5678, 0, 24'h000000};
    vecs[4] = '{3'd7, 32'h8765_4321, 0, 24'h000000};
    vecs[5] = '{3'd3, 32'h0000_0000, 1, 24'h1ffd88};
    flen = 1 + BUTTONS_CNT * (VERIFY ? 2 : 1);

    rst = 1'b0; load_stb = 0; save_stb = 0; load_idx = 0; save_idx = 0; load_word = 0; save_word = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset stb", spi_stb_o, 0);
    checkOutput("reset we", spi_we_o, 0);
    checkOutput("reset erase", spi_erase_o, 0);
    checkOutput("reset adr", spi_adr_o, 0);
    checkOutput("reset dat", spi_dat_o, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset err", err, 0);
    rst = 1'b1;

    for (int s = 1; s <= BUTTONS_CNT; s++)
      applyStimulus(1, 3'(s), 32'h0101_0101 * s, 0, 3'd0, 32'h0);
    waitIdle("startup load");
    checkOutput("load causes no flush", ops.size(), 0);

    $display("[TB] single save of slot 2");
    ops.delete(); ack_delay = 5;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd2, 32'hB02E_7F1E);
    waitIdle("t1");
    checkFlush(0, "t1", 0);
    checkFlash("t1");
    checkOutput("t1 err", err, 0);
    checkOutput("t1 busy", busy, 0);

    $display("[TB] vector table");
    ack_delay = 1;
    for (int v = 0; v < 6; v++) begin
      ops.delete();
      applyStimulus(0, 3'd0, 32'h0, 1, vecs[v].idx, vecs[v].word);
      waitIdle($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d erases", v), countKind(1, 0), vecs[v].exp_erases);
      if (vecs[v].exp_erases != 0) begin
        found = 0; got = '0;
        foreach (ops[i]) if (ops[i].we && ops[i].adr == vecs[v].exp_adr) begin found = 1; got = ops[i].dat; end
        checkOutput($sformatf("vec%0d prog seen", v), found, 1);
        checkOutput($sformatf("vec%0d prog dat", v), got, vecs[v].word);
      end
    end

    $display("[TB] coalesced saves");
    ops.delete(); ack_delay = 2;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd1, 32'hA1A1_0001);
    repeat (4) @(posedge clk);
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd3, 32'hA3A3_0003);
    repeat (4) @(posedge clk);
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd4, 32'hA4A4_0004);
    waitIdle("t2");
    checkOutput("t2 erases", countKind(1, 0), 1);
    d = (ops.size() > 0) ? ops[0].cyc - save_cyc : -1;
    checkOutput("t2 erase after quiet window", (d >= QUIET_CNT && d <= QUIET_CNT + 4), 1);
    checkFlush(0, "t2", 0);

    $display("[TB] save during program");
    ops.delete(); ack_delay = 5;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd1, 32'hB1B1_0001);
    waitOps(progIdx(2) + 1, "t3 prog2");
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd3, 32'hB3B3_0003);
    waitIdle("t3");
    checkOutput("t3 erases", countKind(1, 0), 2);
    checkOutput("t3 total ops", ops.size(), 2 * flen);
    if (ops.size() > progIdx(3))
      checkOutput("t3 first flush slot3", ops[progIdx(3)].dat, model[3]);
    checkFlush(flen, "t3 reflush", 0);
    checkFlash("t3");

    $display("[TB] erase refused every time");
    ops.delete(); ack_delay = 1; rty_erase = 1;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd4, 32'hC4C4_0004);
    waitIdle("t4");
    checkOutput("t4 erase strobes", countKind(1, 0), MAX_RETRY + 1);
    checkOutput("t4 prog strobes", countKind(0, 1), 0);
    checkOutput("t4 err", err, 1);
    checkOutput("t4 busy", busy, 0);
    rty_erase = 0;
    ops.delete();
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd4, 32'hC4C4_0044);
    waitIdle("t4 recover");
    checkFlush(0, "t4 recover", 0);
    checkOutput("t4 err cleared", err, 0);

    $display("[TB] reset during program");
    ops.delete(); ack_delay = 6;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd1, 32'hD1D1_0001);
    waitOps(progIdx(3) + 1, "t5 prog3");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5 stb after reset", spi_stb_o, 0);
    checkOutput("t5 busy after reset", busy, 0);
    rst = 1'b1;
    n = ops.size();
    repeat (40) @(negedge clk);
    checkOutput("t5 no further strobes", ops.size(), n);
    ops.delete();
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd0, 32'h5555_AAAA);
    waitIdle("t5 invalid");
    checkOutput("t5 invalid save no flush", ops.size(), 0);

`ifdef PRESET_VERIFY_EN
    $display("[TB] read-back mismatch on slot 2");
    ops.delete(); ack_delay = 2; corrupt_slot = 2;
    applyStimulus(0, 3'd0, 32'h0, 1, 3'd2, 32'hE2E2_0002);
    waitIdle("t6");
    checkFlush(0, "t6", 2);
    checkFlash("t6");
    checkOutput("t6 corrupt read consumed", corrupt_slot, 0);
    checkOutput("t6 err", err, 0);
`endif

    $display("[TB] random saves");
    rand_delay = 1;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus(1, 3'($urandom_range(1, BUTTONS_CNT)), $urandom, 0, 3'd0, 32'h0);
      nsv = $urandom_range(1, 3);
      for (int j = 0; j < nsv; j++) begin
        idx = (j == nsv - 1) ? 3'($urandom_range(1, BUTTONS_CNT)) : 3'($urandom_range(0, 6));
        applyStimulus($urandom_range(0, 3) == 0, idx, $urandom, 1, idx, $urandom);
        repeat ($urandom_range(0, 2 * QUIET_CNT)) @(posedge clk);
      end
      waitIdle($sformatf("rand%0d", it));
      checkFlash($sformatf("rand%0d", it));
      checkOutput($sformatf("rand%0d err", it), err, 0);
    end

    checkOutput("bus stability", stable_err, 0);
    checkOutput("strobe gap", gap_err, 0);
    checkOutput("address range", adr_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/preset_flash_writer.md
Name: preset_flash_writer

Overview:
- Persists button presets to SPI flash.
- Sits between the MIDI controller's preset memory and the spi_flash bus master, as the write path that complements the existing startup read path.
- Keeps a shadow copy of all preset words and coalesces save events.
- After a quiet period it erases the preset sector and reprograms every word. Retries are bounded, and an error flag reports failure.

Parameters:
BUTTONS_CNT, 4, number of preset slots (one 32-bit word each)
MEMADDR, 24'h1ffd80, flash byte address of slot 1; slot n at MEMADDR + (n-1)*4
QUIET_CNT, 1000000, clk cycles with no new save before a flush starts (10 ms at 100 MHz)
MAX_RETRY, 3, rty retries per flash operation before aborting

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
load_stb  in  1  one-cycle; write load_word into shadow[load_idx] without marking dirty (startup read path)
load_idx  in  3  slot 1..BUTTONS_CNT
load_word  in  32  {status,data1,data2,bits_cnt}
save_stb  in  1  one-cycle; write save_word into shadow[save_idx] and mark dirty
save_idx  in  3  slot 1..BUTTONS_CNT; 0 or >BUTTONS_CNT ignored
save_word  in  32  same packing as load_word
spi_adr_o  out  24  flash address
spi_dat_o  out  32  program data
spi_we_o  out  1  1=program, 0=read
spi_erase_o  out  1  1=sector erase (overrides we)
spi_stb_o  out  1  request strobe
spi_dat_i  in  32  read data
spi_ack_i  in  1  operation complete
spi_rty_i  in  1  operation refused, retry
busy  out  1  FSM not in IDLE
err  out  1  sticky failure flag

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is synchronous, active-low.
  - All outputs 0. dirty=0, pending=0, retry counter=0, state IDLE.
  - Shadow contents are not reset.
- Interface: one clock; reset is synchronous and active-low.
- Shadow writes: load_stb/save_stb take effect in the cycle they are sampled.
  - If both target the same slot in the same cycle, save wins.
  - A save with an invalid index is ignored entirely.
- IDLE: goes to QUIET when dirty=1.
- QUIET: counter cleared on every valid save_stb; goes to ERASE when counter reaches QUIET_CNT-1.
- ERASE: clears dirty on entry.
  - Asserts stb=1, erase=1, we=0, adr=MEMADDR.
  - On ack: drops stb the same cycle and goes to PROG with word index k=1.
- PROG:
  - Asserts stb=1, we=1, erase=0, adr=MEMADDR+(k-1)*4, dat=shadow[k] (sampled at strobe assertion).
  - On ack: drops stb; next PROG if k<BUTTONS_CNT, else DONE.
- Handshake:
  - stb stays high until ack or rty.
  - The next stb is never asserted until ack has been observed low, so stb is low for at least one cycle between operations.
  - Address and data are stable while stb=1.
- rty:
  - Drop stb, increment retry count, re-issue the same operation after ack/rty are low.
  - When retry count exceeds MAX_RETRY: set err, clear stb, go to IDLE, and set dirty=1 only if pending=1.
  - The retry count is cleared on every ack.
- Save while in ERASE/PROG/DONE: sets pending=1 (shadow is updated immediately).
  - A word already programmed may be stale, so the whole flush repeats.
- DONE (one cycle): clears err; goes to QUIET if pending=1 (pending cleared, dirty set), else IDLE.
- Simultaneous ack and rty: ack wins.
- Reset mid-operation: stb deasserts the cycle after rst is sampled low.
  - The partial sector is left as-is; dirty is lost.

Optional Feature:
PRESET_VERIFY_EN
- With the macro defined: after each PROG ack, a VERIFY state issues a read (we=0) at the same address and compares spi_dat_i with shadow[k] on ack.
  - On mismatch, the PROG for slot k is repeated; this counts against MAX_RETRY.
- Without the macro: no VERIFY state; PROG goes straight to the next word.

Test Plan:
1. BUTTONS_CNT=4, QUIET_CNT=16; save slot 2 = 32'hB02E7F1E, ack after 5 cycles -> erase at 1ffd80, then programs at 1ffd80/84/88/8c; 1ffd84 = B02E7F1E; busy low after DONE; err=0.
2. Three saves 5 cycles apart (slots 1, 3, 4) -> exactly one erase, started 16 cycles after the last save.
3. Save slot 3 while PROG k=2 is in flight -> flush completes, returns to QUIET, second full erase+program sequence with the new slot-3 value.
4. rty on every ERASE request, MAX_RETRY=3 -> 4 erase strobes, then err=1, busy=0, no PROG strobe.
5. rst low during PROG k=3 -> stb=0 the next cycle, state IDLE, no further strobes; save_idx=0 with save_stb -> no flush.
6. PRESET_VERIFY_EN, readback of slot 2 returns 0xFFFFFFFF once -> slot 2 reprogrammed, then verified; err=0.
